// File: rtl/buzzer_sequencer.sv
// rtl/buzzer_sequencer.sv - prioritised, preemptive tone sequencer for the panel piezo buzzer
//
// Purpose: single owner of the piezo. Accepts one-cycle tone requests (key click,
// password accept, password reject), arbitrates them FAIL > PASS > KEY with
// preemption, and plays each tone as a timed 50% square wave. The reject tone
// contains a silent gap.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   req_key    one-cycle pulse: keypad click request
//   req_pass   one-cycle pulse: accept tone request
//   req_fail   one-cycle pulse: reject tone request
//   mute       level: forces buzzer low while sequencing continues
//   buzzer     piezo drive, registered
//   busy       high while any tone is in progress
//   tone       current tone: 00 idle, 01 key, 10 pass, 11 fail
//   tone_done  one-cycle pulse when a tone ends naturally

module buzzer_sequencer #(
  parameter int unsigned KEY_HALF       = 50000,
  parameter int unsigned KEY_LEN        = 10000000,
  parameter int unsigned PASS_HALF      = 25000,
  parameter int unsigned PASS_LEN       = 30000000,
  parameter int unsigned FAIL_HALF      = 100000,
  parameter int unsigned FAIL_LEN       = 15000000,
  parameter int unsigned FAIL_GAP_START = 5000000,
  parameter int unsigned FAIL_GAP_END   = 10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_key,
  input  logic       req_pass,
  input  logic       req_fail,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] tone,
  output logic       tone_done
);

  // State encoding doubles as the priority level and as the tone output code.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_KEY  = 2'b01,
    S_PASS = 2'b10,
    S_FAIL = 2'b11
  } state_t;

  localparam logic [31:0] K_HALF  = 32'(KEY_HALF);
  localparam logic [31:0] K_LEN   = 32'(KEY_LEN);
  localparam logic [31:0] P_HALF  = 32'(PASS_HALF);
  localparam logic [31:0] P_LEN   = 32'(PASS_LEN);
  localparam logic [31:0] F_HALF  = 32'(FAIL_HALF);
  localparam logic [31:0] F_LEN   = 32'(FAIL_LEN);
  localparam logic [31:0] F_GAP_S = 32'(FAIL_GAP_START);
  localparam logic [31:0] F_GAP_E = 32'(FAIL_GAP_END);

  state_t      state, state_n, req_state;
  logic [31:0] dur, dur_n, half, half_n;
  logic [31:0] cur_half, cur_len;
  logic        sq, sq_n, done_n, gap_n, req_any;

  // Highest-priority request this cycle; lower ones are simply dropped.
  always_comb begin
    req_state = S_IDLE;
    if (req_fail)      req_state = S_FAIL;
    else if (req_pass) req_state = S_PASS;
    else if (req_key)  req_state = S_KEY;
    req_any = req_fail | req_pass | req_key;
  end

  always_comb begin
    cur_half = K_HALF;
    cur_len  = K_LEN;
    case (state)
      S_PASS: begin cur_half = P_HALF; cur_len = P_LEN; end
      S_FAIL: begin cur_half = F_HALF; cur_len = F_LEN; end
      default: begin cur_half = K_HALF; cur_len = K_LEN; end
    endcase
  end

  always_comb begin
    state_n = state;
    dur_n   = dur;
    half_n  = half;
    sq_n    = sq;
    done_n  = 1'b0;
    // Acceptance is checked first so a request on the terminating edge wins
    // and suppresses tone_done.
    if (req_any && (logic'(1'b1) && (2'(req_state) >= 2'(state)))) begin
      state_n = req_state;
      dur_n   = 32'd0;
      half_n  = 32'd0;
      sq_n    = 1'b1;
    end else if (state != S_IDLE) begin
      if (dur == cur_len - 32'd1) begin
        state_n = S_IDLE;
        dur_n   = 32'd0;
        half_n  = 32'd0;
        sq_n    = 1'b0;
        done_n  = 1'b1;
      end else begin
        dur_n = dur + 32'd1;
        if (half == cur_half - 32'd1) begin
          half_n = 32'd0;
          sq_n   = ~sq;
        end else begin
          half_n = half + 32'd1;
        end
      end
    end
    gap_n = (state_n == S_FAIL) && (dur_n >= F_GAP_S) && (dur_n < F_GAP_E);
  end

  // buzzer is computed from next-state values so the pin comes straight off a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      dur       <= 32'd0;
      half      <= 32'd0;
      sq        <= 1'b0;
      buzzer    <= 1'b0;
      tone_done <= 1'b0;
    end else begin
      state     <= state_n;
      dur       <= dur_n;
      half      <= half_n;
      sq        <= sq_n;
      buzzer    <= sq_n & ~gap_n & ~mute;
      tone_done <= done_n;
    end
  end

  assign busy = (state != S_IDLE);
  assign tone = state;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// tb/tb_buzzer_sequencer.sv - self-checking bench for buzzer_sequencer
module tb_buzzer_sequencer;

  localparam int KH = 2,  KL = 20;
  localparam int PH = 1,  PL = 30;
  localparam int FH = 4,  FL = 24;
  localparam int GS = 8,  GE = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_key = 1'b0, req_pass = 1'b0, req_fail = 1'b0, mute = 1'b0;
  logic       buzzer, busy, tone_done;
  logic [1:0] tone;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  buzzer_sequencer #(
    .KEY_HALF(KH), .KEY_LEN(KL), .PASS_HALF(PH), .PASS_LEN(PL),
    .FAIL_HALF(FH), .FAIL_LEN(FL), .FAIL_GAP_START(GS), .FAIL_GAP_END(GE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_key(req_key), .req_pass(req_pass),
    .req_fail(req_fail), .mute(mute), .buzzer(buzzer), .busy(busy),
    .tone(tone), .tone_done(tone_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tone id and time since the tone started; waveform derived
  // arithmetically from elapsed time.
  int m_tone = 0, m_dur = 0, rp;
  bit m_done = 1'b0, m_mute = 1'b0;

  function automatic int len_of(input int t);
    return (t == 1) ? KL : (t == 2) ? PL : FL;
  endfunction

  function automatic int half_of(input int t);
    return (t == 1) ? KH : (t == 2) ? PH : FH;
  endfunction

  always @(negedge rst_n) begin
    m_tone = 0; m_dur = 0; m_done = 1'b0; m_mute = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_tone = 0; m_dur = 0; m_done = 1'b0; m_mute = 1'b0;
    end else begin
      rp = req_fail ? 3 : req_pass ? 2 : req_key ? 1 : 0;
      m_done = 1'b0;
      m_mute = mute;
      if (rp != 0 && rp >= m_tone) begin
        m_tone = rp; m_dur = 0;
      end else if (m_tone != 0) begin
        if (m_dur == len_of(m_tone) - 1) begin
          m_tone = 0; m_dur = 0; m_done = 1'b1;
        end else begin
          m_dur++;
        end
      end
    end
  end

  logic exp_buz;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_buz = (m_tone != 0) && (((m_dur / half_of(m_tone)) % 2) == 0)
                && !(m_tone == 3 && m_dur >= GS && m_dur < GE) && !m_mute;
      chk("model_buzzer", 32'(buzzer), 32'(exp_buz));
      chk("model_busy", 32'(busy), 32'(m_tone != 0));
      chk("model_tone", 32'(tone), 32'(m_tone));
      chk("model_done", 32'(tone_done), 32'(m_done));
    end
  end

  task automatic step(input bit k, input bit p, input bit f, input bit m);
    @(negedge clk);
    #1;
    req_key = k; req_pass = p; req_fail = f; mute = m;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  logic [19:0] key_pat;
  logic [23:0] fail_pat;
  int r;

  initial begin
    key_pat  = 20'b0011_0011_0011_0011_0011;
    fail_pat = 24'h0F000F;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_buzzer", 32'(buzzer), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tone", 32'(tone), 32'd0);
    chk("rst_done", 32'(tone_done), 32'd0);
    chk_en = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Key click: 1,1,0,0 pattern for 20 cycles, then one tone_done.
    step(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0);
      chk("key_buzzer", 32'(buzzer), 32'(key_pat[i]));
      chk("key_tone", 32'(tone), 32'd1);
    end
    step(0, 0, 0, 0);
    chk("key_done", 32'(tone_done), 32'd1);
    chk("key_end_tone", 32'(tone), 32'd0);
    step(0, 0, 0, 0);
    chk("key_done_once", 32'(tone_done), 32'd0);
    idle(2);

    // Reject tone with silent gap.
    step(0, 0, 1, 0);
    for (int i = 0; i < 24; i++) begin
      step(0, 0, 0, 0);
      chk("fail_buzzer", 32'(buzzer), 32'(fail_pat[i]));
      chk("fail_tone", 32'(tone), 32'd3);
    end
    step(0, 0, 0, 0);
    chk("fail_done", 32'(tone_done), 32'd1);
    idle(2);

    // PASS preempts KEY at dur 5; KEY during PASS ignored.
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("pre_key_tone", 32'(tone), 32'd1);
    for (int i = 0; i < 30; i++) begin
      step(i == 3, 0, 0, 0);
      chk("pass_tone", 32'(tone), 32'd2);
      chk("pass_buzzer", 32'(buzzer), 32'(!(i % 2)));
      chk("pass_no_done", 32'(tone_done), 32'd0);
    end
    step(0, 0, 0, 0);
    chk("pass_done", 32'(tone_done), 32'd1);
    idle(2);

    // Simultaneous requests, then FAIL restart at dur 10.
    step(1, 1, 1, 0);
    for (int i = 0; i <= 10; i++) begin
      step(0, 0, i == 10, 0);
      chk("tri_tone", 32'(tone), 32'd3);
    end
    for (int i = 0; i < 24; i++) begin
      step(0, 0, 0, 0);
      chk("restart_busy", 32'(busy), 32'd1);
      chk("restart_no_done", 32'(tone_done), 32'd0);
    end
    step(0, 0, 0, 0);
    chk("restart_done", 32'(tone_done), 32'd1);
    idle(2);

    // Muted KEY: silent, timing unchanged.
    step(1, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 1);
      chk("mute_buzzer", 32'(buzzer), 32'd0);
      chk("mute_tone", 32'(tone), 32'd1);
    end
    step(0, 0, 0, 1);
    chk("mute_done", 32'(tone_done), 32'd1);
    idle(2);

    // Async reset at dur 12 of PASS.
    step(0, 1, 0, 0);
    for (int i = 0; i < 13; i++) step(0, 0, 0, 0);
    chk("prerst_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_buzzer", 32'(buzzer), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_tone", 32'(tone), 32'd0);
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 35; i++) begin
      step(0, 0, 0, 0);
      chk("post_rst_no_done", 32'(tone_done), 32'd0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      step(r < 6, (r >= 5 && r < 9), (r >= 8 && r < 10),
           ($urandom_range(0, 49) == 0) ? ~mute : mute);
    end
    idle(40);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/buzzer_sequencer.md
Name: buzzer_sequencer

Overview:
- Single-owner controller for the panel's one piezo buzzer.
- Arbitrates tone requests from three sources: the keypad click on any digit/command change, the password-accepted tone and the password-rejected tone.
- Sequences each tone as a timed square wave with fixed priority and preemption. The keypad/lock logic only issues one-cycle request pulses and never drives the buzzer itself.

Parameters:
- KEY_HALF, 50000, click half-period in clk cycles (toggle interval)
- KEY_LEN, 10000000, click duration in cycles
- PASS_HALF, 25000, accept-tone half-period
- PASS_LEN, 30000000, accept-tone duration
- FAIL_HALF, 100000, reject-tone half-period
- FAIL_LEN, 15000000, reject-tone duration
- FAIL_GAP_START, 5000000, first cycle of silent gap inside the reject tone
- FAIL_GAP_END, 10000000, first cycle after the silent gap
- Legal ranges: all HALF >= 1; all LEN >= 2; FAIL_GAP_START < FAIL_GAP_END <= FAIL_LEN. All values fit 32 bits.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_key  input  1  one-cycle pulse: keypad click request
- req_pass  input  1  one-cycle pulse: accept tone request
- req_fail  input  1  one-cycle pulse: reject tone request
- mute  input  1  level: forces buzzer low, sequencing continues
- buzzer  output  1  piezo drive, driven from flops only
- busy  output  1  high while any tone is in progress
- tone  output  2  current tone: 00 idle, 01 key, 10 pass, 11 fail
- tone_done  output  1  one-cycle pulse when a tone ends naturally

Behaviour:
- Reset (async, rst_n=0): state IDLE; all counters 0; square-wave flop sq=0; buzzer=0, busy=0, tone=00, tone_done=0. A reset asserted mid-tone aborts it immediately with no tone_done.
- State machine: IDLE, KEY, PASS, FAIL. Priority is FAIL > PASS > KEY.
- Accepting a request at a rising edge (request high at that edge):
  - Accepted if its priority is >= that of the current state (IDLE is lowest).
  - Enters the request's state with dur=0, half=0, sq=1, so buzzer=1 in the following cycle unless muted.
  - A same-priority request restarts the tone from dur=0.
  - A lower-priority request is dropped, not queued.
  - Simultaneous requests: the highest wins; the others are dropped.
  - A preempted tone ends without tone_done.
- In a tone state with no accepted request, each edge:
  - dur increments and half increments.
  - If half == HALF-1, sq toggles and half returns to 0.
  - Output period is therefore 2*HALF cycles, 50% duty.
- Termination: at the edge where dur == LEN-1 (with no accepted request):
  - state goes to IDLE; sq=0, dur=0, half=0;
  - tone_done=1 for exactly the next cycle.
  - A tone occupies exactly LEN cycles of busy=1.
- Acceptance beats termination: a request accepted on the terminating edge is taken, and tone_done is not pulsed.
- buzzer = sq AND NOT gap AND NOT mute, built from registered state only.
  - gap=1 only in FAIL while FAIL_GAP_START <= dur < FAIL_GAP_END.
  - The square-wave phase keeps running through the gap and while muted.
- busy = (state != IDLE). tone encodes the state, with the same timing as busy.
- Counters are 32-bit unsigned and never wrap, because termination occurs first.

Test Plan:
- Bench parameters: KEY_HALF=2, KEY_LEN=20, PASS_HALF=1, PASS_LEN=30, FAIL_HALF=4, FAIL_GAP_START=8, FAIL_GAP_END=16, FAIL_LEN=24.
- Reset, then a req_key pulse:
  - buzzer pattern 1,1,0,0 repeating; busy=1 and tone=01 for 20 cycles;
  - then tone_done pulses once, and buzzer=0, tone=00.
- req_fail pulse:
  - buzzer high for dur 0-3, low for 4-7, forced 0 for dur 8-15, high for 16-19, low for 20-23;
  - tone_done after 24 cycles.
- req_pass at dur=5 of a KEY tone:
  - switches to tone=10 with dur=0 and a toggling-every-cycle pattern; no tone_done for KEY;
  - a req_key issued during PASS is ignored, and PASS completes in 30 cycles.
- req_key, req_pass and req_fail in the same cycle from IDLE: tone=11 only; a subsequent req_fail at dur=10 restarts FAIL (busy for 24 more cycles).
- mute=1 throughout a KEY tone: buzzer stays 0, while busy, tone and tone_done timing are identical to the unmuted case.
- rst_n low at dur=12 of PASS: buzzer, busy and tone go to 0 immediately without waiting for a clock edge; no tone_done after release.
